rx_burst: RTL and testbench
===========================

Name: rx_burst

Overview:
- Receive-side counterpart of the GMSK burst transmitter. Consumes demodulated I/Q samples and hard-decision symbols from the demodulator.
- Detects burst power envelope with hysteresis, locates payload start after the all-ones preamble, checks payload against the transmitter's LFSR sequence.
- Reports per-burst symbol count, bit errors and pass/fail to the link-test/debug logic.

Parameters:
SAMPLE_BITS, 9, signed I/Q sample width
POWER_WINDOW_LOG2, 4, leaky-integrator time constant (2^N samples)
PAYLOAD_SYMBOLS, 8, payload length in symbols (1..255)
PREAMBLE_TIMEOUT, 64, max preamble symbols before abort (1..255)
LFSR_TAPS, 8'h8e, Galois LFSR taps; must match transmitter
LFSR_SEED, 8'h01, LFSR value at start of each burst

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
iq_valid_i  input  1  I/Q sample qualifier, one cycle per sample
inphase_i  input  SAMPLE_BITS  signed in-phase sample
quadrature_i  input  SAMPLE_BITS  signed quadrature sample
symbol_strobe_i  input  1  one-cycle pulse, symbol_i valid
symbol_i  input  1  hard-decision demodulated symbol
threshold_on_i  input  SAMPLE_BITS+1  energy level asserting carrier
threshold_off_i  input  SAMPLE_BITS+1  energy level deasserting carrier (<= on)
carrier_detect  output  1  envelope above hysteresis band
burst_active  output  1  high in PREAMBLE or PAYLOAD
burst_done  output  1  one-cycle pulse, result outputs updated
burst_ok  output  1  last burst complete with zero errors
burst_aborted  output  1  last burst aborted (carrier loss or timeout)
symbols_received  output  8  payload symbols compared in last burst
bit_errors  output  8  mismatches in last burst, saturating at 255

Behaviour:
- Reset (async, reset_n low): all outputs 0, state IDLE, accumulator 0, LFSR = LFSR_SEED. Mid-operation reset discards the burst; no burst_done.
- Magnitude per valid sample: mag = |I|+|Q|, unsigned SAMPLE_BITS+1 bits (|-256|=256, max 512). Uses no multipliers.
- Accumulator acc, width SAMPLE_BITS+1+POWER_WINDOW_LOG2. On iq_valid_i: acc <= acc + mag - (acc >> POWER_WINDOW_LOG2). energy = acc >> POWER_WINDOW_LOG2.
- carrier_detect is registered and updated only on iq_valid_i: set when energy > threshold_on_i, cleared when energy < threshold_off_i, otherwise held. Latency: one cycle after the sample that crosses the threshold.
- LFSR reference: expected bit = lfsr[1]. Advance: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0). With defaults the sequence is 0,1,1,0,0,0,1,1.
- FSM, evaluated on symbol_strobe_i unless stated otherwise:
  - IDLE: lfsr=SEED, counters cleared. Moves to PREAMBLE on the cycle carrier_detect is 1.
  - PREAMBLE: each symbol 1 increments the preamble counter. Symbol 0 is the sync: it counts as payload symbol 0, compared against lfsr[1] of the seed (expected 0, so no error); symbols_received becomes 1, LFSR advances, go to PAYLOAD. If the preamble count reaches PREAMBLE_TIMEOUT with no 0, abort.
  - PAYLOAD: each symbol is compared against lfsr[1]. A mismatch increments the error count (saturating). symbols_received increments and the LFSR advances. When symbols_received reaches PAYLOAD_SYMBOLS, complete, go to TAIL.
  - TAIL: ignores symbols. Returns to IDLE when carrier_detect is 0, so one burst is never counted twice.
- Completion: burst_done pulses 1 cycle. burst_ok = (bit_errors==0), burst_aborted=0.
- Abort: burst_done pulses with burst_ok=0 and burst_aborted=1; symbols_received and bit_errors hold the partial counts.
  - Carrier loss in PREAMBLE/PAYLOAD: abort, go to IDLE.
  - Timeout: abort, go to TAIL.
- Simultaneous symbol_strobe_i and carrier drop in the same cycle: the symbol is processed first; if it completes the burst, completion wins, else abort.
- Result outputs are held from one burst_done to the next burst_done. burst_active is combinational from state.

Test Plan:
- Reset: assert reset_n=0 mid-PAYLOAD -> all outputs 0 immediately, no burst_done; after release, state IDLE.
- Clean burst: 32 samples I=Q=100 (thresholds on=150, off=50), five 1 symbols, then 0,1,1,0,0,0,1,1 -> burst_done once, burst_ok=1, symbols_received=8, bit_errors=0.
- Errors: same burst with symbol 3 and 6 inverted -> bit_errors=2, burst_ok=0, burst_aborted=0.
- Carrier loss: I=Q=0 after 4 payload symbols -> carrier drops, burst_done, burst_aborted=1, symbols_received=4.
- Preamble timeout: carrier held, 64 consecutive 1 symbols -> abort pulse at symbol 64, FSM stays TAIL until carrier drops, no second burst_done.
- Hysteresis: energy ramps to 160, falls to 100, then to 40 -> carrier_detect rises at >150, stays at 100, falls at <50.

Source files
------------

// File: rtl/rx_burst.sv
// Receive-side burst checker: power envelope with hysteresis, preamble sync,
// and payload comparison against the transmitter's Galois LFSR sequence.
module rx_burst #(
  parameter int          SAMPLE_BITS       = 9,
  parameter int          POWER_WINDOW_LOG2 = 4,
  parameter int          PAYLOAD_SYMBOLS   = 8,
  parameter int          PREAMBLE_TIMEOUT  = 64,
  parameter logic [7:0]  LFSR_TAPS         = 8'h8e,
  parameter logic [7:0]  LFSR_SEED         = 8'h01
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   iq_valid_i,
  input  logic [SAMPLE_BITS-1:0] inphase_i,
  input  logic [SAMPLE_BITS-1:0] quadrature_i,
  input  logic                   symbol_strobe_i,
  input  logic                   symbol_i,
  input  logic [SAMPLE_BITS:0]   threshold_on_i,
  input  logic [SAMPLE_BITS:0]   threshold_off_i,
  output logic                   carrier_detect,
  output logic                   burst_active,
  output logic                   burst_done,
  output logic                   burst_ok,
  output logic                   burst_aborted,
  output logic [7:0]             symbols_received,
  output logic [7:0]             bit_errors
);

  localparam int AW = SAMPLE_BITS + 1 + POWER_WINDOW_LOG2;
  localparam logic [7:0] PAY_LAST = 8'(PAYLOAD_SYMBOLS);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_TAIL = 2'd3;

  // |v| of a two's-complement sample; the extra bit holds |-2^(N-1)|
  function automatic logic [SAMPLE_BITS:0] abs_val(input logic [SAMPLE_BITS-1:0] v);
    logic signed [SAMPLE_BITS:0] ext;
    ext = signed'({v[SAMPLE_BITS-1], v});
    return v[SAMPLE_BITS-1] ? unsigned'(-ext) : unsigned'(ext);
  endfunction

  logic [AW-1:0]          acc_q, acc_d;
  logic [SAMPLE_BITS:0]   mag, energy_d;
  logic                   carrier_q, carrier_d;
  logic [1:0]             state_q, state_d;
  logic [7:0]             lfsr_q, lfsr_d, lfsr_adv;
  logic [7:0]             pre_q, pre_d, sym_q, sym_d, err_q, err_d, err_inc;
  logic                   done_q, done_d, ok_q, ok_d, abort_q, abort_d;
  logic [7:0]             sym_out_q, sym_out_d, err_out_q, err_out_d;
  logic                   take_sym, complete, timeout, lost;

  assign mag      = abs_val(inphase_i) + abs_val(quadrature_i);
  assign acc_d    = iq_valid_i ? acc_q + {{POWER_WINDOW_LOG2{1'b0}}, mag} - (acc_q >> POWER_WINDOW_LOG2)
                               : acc_q;
  assign energy_d = acc_d[AW-1:POWER_WINDOW_LOG2];

  always_comb begin
    carrier_d = carrier_q;
    if (iq_valid_i) begin
      if (energy_d > threshold_on_i)       carrier_d = 1'b1;
      else if (energy_d < threshold_off_i) carrier_d = 1'b0;
    end
  end

  assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
  assign err_inc  = ((symbol_i != lfsr_q[1]) && (err_q != 8'hff)) ? err_q + 8'd1 : err_q;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    pre_d     = pre_q;
    sym_d     = sym_q;
    err_d     = err_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    abort_d   = abort_q;
    sym_out_d = sym_out_q;
    err_out_d = err_out_q;
    take_sym  = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    lost      = 1'b0;
    case (state_q)
      S_IDLE: begin
        lfsr_d = LFSR_SEED;
        pre_d  = 8'd0;
        sym_d  = 8'd0;
        err_d  = 8'd0;
        if (carrier_q) state_d = S_PRE;
      end
      S_PRE: begin
        if (symbol_strobe_i) begin
          if (symbol_i) begin
            pre_d   = pre_q + 8'd1;
            timeout = (pre_q == PRE_LAST);
          end else begin
            take_sym = 1'b1;
          end
        end
        lost = !carrier_q;
      end
      S_PAY: begin
        take_sym = symbol_strobe_i;
        lost     = !carrier_q;
      end
      default: begin
        if (!carrier_q) state_d = S_IDLE;
      end
    endcase

    // The sync zero is payload symbol 0, so both states share this path
    if (take_sym) begin
      sym_d    = sym_q + 8'd1;
      err_d    = err_inc;
      lfsr_d   = lfsr_adv;
      state_d  = S_PAY;
      complete = (sym_d == PAY_LAST);
    end

    if (complete || timeout || lost) begin
      done_d    = 1'b1;
      ok_d      = complete && (err_d == 8'd0);
      abort_d   = !complete;
      sym_out_d = sym_d;
      err_out_d = err_d;
      state_d   = (complete || timeout) ? S_TAIL : S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      carrier_q <= 1'b0;
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      pre_q     <= 8'd0;
      sym_q     <= 8'd0;
      err_q     <= 8'd0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      abort_q   <= 1'b0;
      sym_out_q <= 8'd0;
      err_out_q <= 8'd0;
    end else begin
      acc_q     <= acc_d;
      carrier_q <= carrier_d;
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      pre_q     <= pre_d;
      sym_q     <= sym_d;
      err_q     <= err_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      abort_q   <= abort_d;
      sym_out_q <= sym_out_d;
      err_out_q <= err_out_d;
    end
  end

  assign carrier_detect   = carrier_q;
  assign burst_active     = (state_q == S_PRE) || (state_q == S_PAY);
  assign burst_done       = done_q;
  assign burst_ok         = ok_q;
  assign burst_aborted    = abort_q;
  assign symbols_received = sym_out_q;
  assign bit_errors       = err_out_q;

endmodule

// File: tb/tb_rx_burst.sv
// Bench for rx_burst: directed bursts checked every cycle against a behavioural
// model, plus literal expectations after each scenario.
module tb_rx_burst;
  localparam int SB = 9;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          iq_valid_i = 1'b0;
  logic [SB-1:0] inphase_i = '0;
  logic [SB-1:0] quadrature_i = '0;
  logic          symbol_strobe_i = 1'b0;
  logic          symbol_i = 1'b0;
  logic [SB:0]   threshold_on_i = 10'd150;
  logic [SB:0]   threshold_off_i = 10'd50;
  logic          carrier_detect, burst_active, burst_done, burst_ok, burst_aborted;
  logic [7:0]    symbols_received, bit_errors;

  rx_burst #(
    .SAMPLE_BITS(SB), .POWER_WINDOW_LOG2(4), .PAYLOAD_SYMBOLS(8),
    .PREAMBLE_TIMEOUT(64), .LFSR_TAPS(8'h8e), .LFSR_SEED(8'h01)
  ) dut (
    .clock(clock), .reset_n(reset_n), .iq_valid_i(iq_valid_i),
    .inphase_i(inphase_i), .quadrature_i(quadrature_i),
    .symbol_strobe_i(symbol_strobe_i), .symbol_i(symbol_i),
    .threshold_on_i(threshold_on_i), .threshold_off_i(threshold_off_i),
    .carrier_detect(carrier_detect), .burst_active(burst_active),
    .burst_done(burst_done), .burst_ok(burst_ok), .burst_aborted(burst_aborted),
    .symbols_received(symbols_received), .bit_errors(bit_errors)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference payload bits straight from the LFSR definition
  bit ref_bits[8];
  function automatic bit [7:0] lfsr_step(input bit [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'h8e : 8'h00);
  endfunction
  function automatic int mag_of(input logic [SB-1:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  // Behavioural model: envelope as integer arithmetic, burst as booleans + counts
  int  m_acc = 0, m_pre = 0, m_nsym = 0, m_nerr = 0, m_energy;
  bit  m_car = 0, m_cp, m_act = 0, m_sync = 0, m_tail = 0, m_end;
  bit  e_done = 0, e_ok = 0, e_ab = 0;
  int  e_sym = 0, e_err = 0;

  task automatic finish_burst(input bit ok, input bit ab);
    e_done = 1; e_ok = ok; e_ab = ab; e_sym = m_nsym; e_err = m_nerr;
  endtask

  initial begin
    bit [7:0] s;
    s = 8'h01;
    for (int i = 0; i < 8; i++) begin
      ref_bits[i] = s[1];
      s = lfsr_step(s);
    end
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_acc = 0; m_car = 0; m_act = 0; m_tail = 0; m_sync = 0;
        m_pre = 0; m_nsym = 0; m_nerr = 0;
        e_done = 0; e_ok = 0; e_ab = 0; e_sym = 0; e_err = 0;
      end else begin
        m_cp = m_car;
        e_done = 0;
        m_end = 0;
        if (iq_valid_i) begin
          m_acc = m_acc + mag_of(inphase_i) + mag_of(quadrature_i) - m_acc / 16;
          m_energy = m_acc / 16;
          if (m_energy > int'(threshold_on_i)) m_car = 1;
          else if (m_energy < int'(threshold_off_i)) m_car = 0;
        end
        if (m_tail) begin
          if (!m_cp) m_tail = 0;
        end else if (!m_act) begin
          if (m_cp) begin
            m_act = 1; m_sync = 0; m_pre = 0; m_nsym = 0; m_nerr = 0;
          end
        end else begin
          if (symbol_strobe_i) begin
            if (!m_sync && symbol_i) begin
              m_pre++;
              if (m_pre == 64) begin finish_burst(0, 1); m_end = 1; m_tail = 1; end
            end else begin
              m_sync = 1;
              if (symbol_i != ref_bits[m_nsym]) m_nerr = (m_nerr < 255) ? m_nerr + 1 : 255;
              m_nsym++;
              if (m_nsym == 8) begin finish_burst(m_nerr == 0, 0); m_end = 1; m_tail = 1; end
            end
          end
          if (!m_end && !m_cp) begin finish_burst(0, 1); m_end = 1; end
          if (m_end) m_act = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (burst_done === 1'b1) n_done++;
      check("cyc_carrier", 32'(carrier_detect), 32'(m_car));
      check("cyc_active",  32'(burst_active),   32'(m_act));
      check("cyc_done",    32'(burst_done),     32'(e_done));
      check("cyc_ok",      32'(burst_ok),       32'(e_ok));
      check("cyc_aborted", 32'(burst_aborted),  32'(e_ab));
      check("cyc_symbols", 32'(symbols_received), 32'(e_sym));
      check("cyc_errors",  32'(bit_errors),     32'(e_err));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic samples(input int n, input int v);
    iq_valid_i = 1'b1;
    inphase_i = v[SB-1:0];
    quadrature_i = v[SB-1:0];
    symbol_strobe_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_sym(input bit b, input int v);
    iq_valid_i = 1'b1;
    inphase_i = v[SB-1:0];
    quadrature_i = v[SB-1:0];
    symbol_i = b;
    symbol_strobe_i = 1'b1;
    tick();
    symbol_strobe_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_results(input string tag, input int ok, input int ab, input int sym, input int err);
    check({tag, "_ok"},      32'(burst_ok),         ok);
    check({tag, "_aborted"}, 32'(burst_aborted),    ab);
    check({tag, "_symbols"}, 32'(symbols_received), sym);
    check({tag, "_errors"},  32'(bit_errors),       err);
  endtask

  int d0;
  bit [7:0] pl_clean = 8'b11000110;
  bit [7:0] pl_err   = 8'b10001110;
  bit [7:0] seq_lit  = 8'b11000110;

  initial begin
    for (int i = 0; i < 8; i++) check("ref_seq", 32'(ref_bits[i]), 32'(seq_lit[i]));

    repeat (3) tick();
    check("rst_carrier", 32'(carrier_detect), 0);
    check("rst_active",  32'(burst_active), 0);
    check_results("rst", 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();

    // Clean burst
    d0 = n_done;
    samples(32, 100);
    check("clean_carrier_up", 32'(carrier_detect), 1);
    check("clean_active", 32'(burst_active), 1);
    repeat (5) send_sym(1'b1, 100);
    for (int i = 0; i < 8; i++) send_sym(pl_clean[i], 100);
    check_results("clean", 1, 0, 8, 0);
    samples(48, 0);
    check("clean_done_count", n_done - d0, 1);
    check("clean_carrier_down", 32'(carrier_detect), 0);

    // Burst with payload symbols 3 and 6 inverted
    d0 = n_done;
    samples(32, 100);
    repeat (5) send_sym(1'b1, 100);
    for (int i = 0; i < 8; i++) send_sym(pl_err[i], 100);
    check_results("errs", 0, 0, 8, 2);
    samples(48, 0);
    check("errs_done_count", n_done - d0, 1);

    // Carrier loss after 4 payload symbols
    d0 = n_done;
    samples(32, 100);
    repeat (5) send_sym(1'b1, 100);
    for (int i = 0; i < 4; i++) send_sym(pl_clean[i], 100);
    samples(48, 0);
    check("loss_done_count", n_done - d0, 1);
    check_results("loss", 0, 1, 4, 0);
    check("loss_active", 32'(burst_active), 0);

    // Preamble timeout, then carrier held: no second report
    d0 = n_done;
    samples(32, 100);
    repeat (64) send_sym(1'b1, 100);
    check("tmo_done_count", n_done - d0, 1);
    check_results("tmo", 0, 1, 0, 0);
    check("tmo_active", 32'(burst_active), 0);
    check("tmo_carrier", 32'(carrier_detect), 1);
    repeat (4) send_sym(1'b0, 100);
    samples(48, 0);
    check("tmo_done_total", n_done - d0, 1);
    check("tmo_active_idle", 32'(burst_active), 0);

    // Hysteresis: energy toward 160, then 100, then 40
    samples(80, 80);
    check("hyst_high", 32'(carrier_detect), 1);
    samples(80, 50);
    check("hyst_mid", 32'(carrier_detect), 1);
    samples(80, 20);
    check("hyst_low", 32'(carrier_detect), 0);
    samples(8, 0);

    // Asynchronous reset in the middle of the payload
    samples(32, 100);
    repeat (5) send_sym(1'b1, 100);
    for (int i = 0; i < 3; i++) send_sym(pl_clean[i], 100);
    check("prerst_active", 32'(burst_active), 1);
    d0 = n_done;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_carrier", 32'(carrier_detect), 0);
    check("midrst_active",  32'(burst_active), 0);
    check("midrst_done",    32'(burst_done), 0);
    check_results("midrst", 0, 0, 0, 0);
    samples(2, 0);
    reset_n = 1'b1;
    samples(10, 0);
    check("postrst_done_count", n_done - d0, 0);
    check("postrst_active", 32'(burst_active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
